uart_reg_bank: RTL and testbench
================================

Name: uart_reg_bank

Overview:
- Parametrised successor to the UART register block. It sits between the APB slave decode and the UART core.
- Adds TX and RX byte FIFOs, a programmable baud divisor, sticky write-1-to-clear status, and interrupt enable/irq generation.
- Adds registered, single-pulse address-error flags, with separate read and write strobes.

Parameters:
ADDR_W, 12, register address width
DATA_W, 32, bus data width (>=16)
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)
DIV_W, 16, baud divisor width (<=DATA_W)
DIV_RESET, 54, baud divisor reset value

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
waddr  in  ADDR_W  write address
raddr  in  ADDR_W  read address
wdata  in  DATA_W  write data
pwrite  in  1  write strobe, one cycle per access
pread  in  1  read strobe, one cycle per access
rdata  out  DATA_W  read data, registered
wadderr  out  1  one-cycle pulse: bad write address
radderr  out  1  one-cycle pulse: bad read address
tx_valid  out  1  TX FIFO non-empty
tx_data  out  8  TX FIFO head (show-ahead)
tx_ready  in  1  core accepts head; pops when tx_valid & tx_ready
tx_done  in  1  pulse, frame transmitted
rx_valid  in  1  pulse, rx_data/parity_error valid
rx_data  in  8  received byte
parity_error  in  1  qualified by rx_valid
data_bit_num  out  2  CFG[1:0]
stop_bit_num  out  1  CFG[2]
parity_en  out  1  CFG[3]
parity_type  out  1  CFG[4]
baud_div  out  DIV_W  BAUD register
irq  out  1  interrupt, registered

Behaviour:
Register map:
- 0x000 TX_DATA, W: push wdata[7:0]. Read returns 0, no error.
- 0x004 RX_DATA, R: pop. rdata={0,head[7:0]}. If empty: rdata=0 and RX_UNDERFLOW set. Write sets wadderr.
- 0x008 CFG, RW: bits [4:0]; upper bits read 0.
- 0x00C BAUD, RW: [DIV_W-1:0].
- 0x010 STATUS, R, W1C on bits [8:4]:
  - Live bits: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full.
  - Sticky bits: [4] TX_DONE, [5] RX_OVERRUN, [6] PARITY_ERR, [7] TX_OVERFLOW, [8] RX_UNDERFLOW.
- 0x014 IER, RW: bits [8:0].
- 0x018 LEVEL, R: [15:8] rx_count, [7:0] tx_count. Write sets wadderr.
- Any other address: wadderr/radderr.

Access rules:
- pwrite and pread may coincide; they are serviced independently.
- rdata updates the cycle after pread and holds until the next pread.
- wadderr/radderr assert the cycle after the offending strobe, for one cycle only.

FIFOs:
- Counts are $clog2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.
- Push when full is dropped and sets TX_OVERFLOW / RX_OVERRUN. Exception: if a pop occurs in the same cycle, the push is accepted and the count is unchanged.
- Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
- rx_valid with parity_error still pushes the byte and also sets PARITY_ERR.

Sticky bits:
- Set by the event and cleared by writing 1 to the bit.
- Set and clear in the same cycle: set wins.
- TX_DONE is set by tx_done.

irq:
- Registered: irq <= |(STATUS[8:4] & IER[8:4]) | (IER[0] & tx_empty) | (IER[2] & ~rx_empty).
- IER[1] and IER[3] are reserved, read back, no effect.

Reset (synchronous, active-high):
- FIFOs flushed, counts and pointers 0.
- CFG=0, IER=0, BAUD=DIV_RESET, sticky bits 0.
- rdata=0, wadderr=0, radderr=0, irq=0, tx_valid=0, tx_data=0.
- Asserting reset mid-transfer discards FIFO contents; tx_valid drops the cycle after reset.

Test Plan:
1. Reset, then read 0x00C, 0x010, 0x018: 54, 0x005 (tx_empty, rx_empty), 0.
2. Write 0x41, 0x42, 0x43 to 0x000 with tx_ready=0: LEVEL[7:0]=3, tx_data=0x41. Assert tx_ready for 3 cycles: bytes 0x41, 0x42, 0x43 appear in order, then tx_valid=0 and tx_empty=1.
3. Write 9 bytes with TX_DEPTH=8 and tx_ready=0: tx_full=1, STATUS[7]=1, 9th byte lost. Write 0x080 to 0x010: STATUS[7]=0.
4. Apply 9 rx_valid pulses (bytes 1..9), then read 0x004 eight times: returns 1..8 with RX_OVERRUN=1. Ninth read returns 0 with RX_UNDERFLOW=1.
5. IER=0x040, then rx_valid with parity_error=1: irq=1 one cycle after PARITY_ERR is set. W1C 0x040 in the same cycle as a new parity_error: bit stays 1.
6. Write to 0x020 and read 0x01C: wadderr and radderr each pulse once for exactly one cycle. Register contents unchanged.

Source files
------------

// File: rtl/uart_reg_bank.sv
// UART register bank: APB-side register map, TX/RX byte FIFOs, baud divisor,
// sticky write-1-to-clear status and interrupt generation.
module uart_reg_bank #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TX_DEPTH  = 8,
    parameter int unsigned RX_DEPTH  = 8,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DIV_RESET = 54
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pwrite,
    input  logic              pread,
    output logic [DATA_W-1:0] rdata,
    output logic              wadderr,
    output logic              radderr,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    input  logic              tx_done,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              parity_error,
    output logic [1:0]        data_bit_num,
    output logic              stop_bit_num,
    output logic              parity_en,
    output logic              parity_type,
    output logic [DIV_W-1:0]  baud_div,
    output logic              irq
);

    localparam int unsigned TX_PW = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW = TX_PW + 1;
    localparam int unsigned RX_PW = $clog2(RX_DEPTH);
    localparam int unsigned RX_CW = RX_PW + 1;

    localparam logic [ADDR_W-1:0] ADDR_TX     = ADDR_W'(32'h000);
    localparam logic [ADDR_W-1:0] ADDR_RX     = ADDR_W'(32'h004);
    localparam logic [ADDR_W-1:0] ADDR_CFG    = ADDR_W'(32'h008);
    localparam logic [ADDR_W-1:0] ADDR_BAUD   = ADDR_W'(32'h00C);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(32'h010);
    localparam logic [ADDR_W-1:0] ADDR_IER    = ADDR_W'(32'h014);
    localparam logic [ADDR_W-1:0] ADDR_LEVEL  = ADDR_W'(32'h018);

    logic [7:0]        tx_mem [TX_DEPTH];
    logic [TX_PW-1:0]  tx_wptr_q, tx_rptr_q;
    logic [TX_CW-1:0]  tx_cnt_q;
    logic [7:0]        rx_mem [RX_DEPTH];
    logic [RX_PW-1:0]  rx_wptr_q, rx_rptr_q;
    logic [RX_CW-1:0]  rx_cnt_q;

    logic [4:0]        cfg_q;
    logic [DIV_W-1:0]  baud_q;
    logic [8:0]        ier_q;
    logic [4:0]        sticky_q;
    logic [DATA_W-1:0] rdata_q;
    logic              wadderr_q, radderr_q, irq_q;

    logic wr_tx, wr_cfg, wr_baud, wr_stat, wr_ier, wr_bad;
    logic rd_rx, rd_hit, rd_bad;
    logic tx_empty, tx_full, tx_pop, tx_push, tx_ovf;
    logic rx_empty, rx_full, rx_pop, rx_push, rx_ovr, rx_unf;
    logic [4:0]        sticky_set, sticky_clr;
    logic [8:0]        status;
    logic [DATA_W-1:0] rd_val;
    logic              irq_d;
    logic              unused_wdata;

    assign wr_tx   = pwrite && (waddr == ADDR_TX);
    assign wr_cfg  = pwrite && (waddr == ADDR_CFG);
    assign wr_baud = pwrite && (waddr == ADDR_BAUD);
    assign wr_stat = pwrite && (waddr == ADDR_STATUS);
    assign wr_ier  = pwrite && (waddr == ADDR_IER);
    assign wr_bad  = pwrite && !(wr_tx || wr_cfg || wr_baud || wr_stat || wr_ier);

    assign rd_rx  = pread && (raddr == ADDR_RX);
    assign rd_bad = pread && !rd_hit;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));

    // A pop frees the slot a same-cycle push into a full FIFO needs.
    assign tx_pop  = !tx_empty && tx_ready;
    assign tx_push = wr_tx && (!tx_full || tx_pop);
    assign tx_ovf  = wr_tx && tx_full && !tx_pop;
    assign rx_pop  = rd_rx && !rx_empty;
    assign rx_push = rx_valid && (!rx_full || rx_pop);
    assign rx_ovr  = rx_valid && rx_full && !rx_pop;
    assign rx_unf  = rd_rx && rx_empty;

    assign sticky_set = {rx_unf, tx_ovf, rx_valid && parity_error, rx_ovr, tx_done};
    assign sticky_clr = wr_stat ? wdata[8:4] : 5'b0;
    assign status     = {sticky_q, rx_full, rx_empty, tx_full, tx_empty};

    assign irq_d = (|(sticky_q & ier_q[8:4])) || (ier_q[0] && tx_empty) ||
                   (ier_q[2] && !rx_empty);

    always_comb begin
        rd_val = '0;
        rd_hit = 1'b1;
        case (raddr)
            ADDR_TX:     rd_val = '0;
            ADDR_RX:     rd_val = rx_empty ? '0 : DATA_W'(rx_mem[rx_rptr_q]);
            ADDR_CFG:    rd_val = DATA_W'(cfg_q);
            ADDR_BAUD:   rd_val = DATA_W'(baud_q);
            ADDR_STATUS: rd_val = DATA_W'(status);
            ADDR_IER:    rd_val = DATA_W'(ier_q);
            ADDR_LEVEL:  rd_val = DATA_W'({8'(rx_cnt_q), 8'(tx_cnt_q)});
            default:     rd_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            cfg_q     <= '0;
            baud_q    <= DIV_W'(DIV_RESET);
            ier_q     <= '0;
            sticky_q  <= '0;
            rdata_q   <= '0;
            wadderr_q <= 1'b0;
            radderr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + TX_PW'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + TX_PW'(1);
            tx_cnt_q <= tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
            if (rx_push) rx_wptr_q <= rx_wptr_q + RX_PW'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + RX_PW'(1);
            rx_cnt_q <= rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);

            if (wr_cfg)  cfg_q  <= wdata[4:0];
            if (wr_baud) baud_q <= wdata[DIV_W-1:0];
            if (wr_ier)  ier_q  <= wdata[8:0];
            // Set after clear so a simultaneous event wins over W1C.
            sticky_q <= (sticky_q & ~sticky_clr) | sticky_set;

            if (pread) rdata_q <= rd_val;
            wadderr_q <= wr_bad;
            radderr_q <= rd_bad;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= wdata[7:0];
        if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
    end

    assign unused_wdata = ^{wdata, 1'b0};

    assign rdata        = rdata_q;
    assign wadderr      = wadderr_q;
    assign radderr      = radderr_q;
    assign irq          = irq_q;
    assign tx_valid     = !tx_empty;
    assign tx_data      = tx_empty ? 8'h00 : tx_mem[tx_rptr_q];
    assign data_bit_num = cfg_q[1:0];
    assign stop_bit_num = cfg_q[2];
    assign parity_en    = cfg_q[3];
    assign parity_type  = cfg_q[4];
    assign baud_div     = baud_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Bench for uart_reg_bank: directed register-map scenarios followed by
// randomized traffic checked against a queue-based reference model.
module tb_uart_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] waddr, raddr;
    logic [31:0] wdata;
    logic        pwrite, pread;
    logic [31:0] rdata;
    logic        wadderr, radderr;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready, tx_done, rx_valid;
    logic [7:0]  rx_data;
    logic        parity_error;
    logic [1:0]  data_bit_num;
    logic        stop_bit_num, parity_en, parity_type;
    logic [15:0] baud_div;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [11:0] wa_tab [8] = '{12'h000, 12'h000, 12'h008, 12'h00C, 12'h010, 12'h014,
                                12'h004, 12'h024};
    logic [11:0] ra_tab [8] = '{12'h004, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                                12'h018, 12'h01C};

    uart_reg_bank dut (
        .clk(clk), .reset(reset), .waddr(waddr), .raddr(raddr), .wdata(wdata),
        .pwrite(pwrite), .pread(pread), .rdata(rdata), .wadderr(wadderr),
        .radderr(radderr), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_done(tx_done), .rx_valid(rx_valid), .rx_data(rx_data),
        .parity_error(parity_error), .data_bit_num(data_bit_num),
        .stop_bit_num(stop_bit_num), .parity_en(parity_en), .parity_type(parity_type),
        .baud_div(baud_div), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        waddr = a; wdata = d; pwrite = 1'b1;
        tick();
        pwrite = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        raddr = a; pread = 1'b1;
        tick();
        pread = 1'b0;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        total++;
        if ({rdata, tx_valid, irq, wadderr, radderr} !== 36'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {rdata, tx_valid, irq, wadderr, radderr});
        end
        bus_read(12'h00C, v);
        total++;
        if (v !== 32'd54) begin bad++; $display("FAIL reset_baud got=%0d want=54", v); end
        bus_read(12'h010, v);
        total++;
        if (v !== 32'h005) begin bad++; $display("FAIL reset_status got=%h want=005", v); end
        bus_read(12'h018, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_level got=%h want=0", v); end
    endtask

    task automatic test_tx_fifo();
        logic [31:0] v;
        logic [7:0]  exp [3] = '{8'h41, 8'h42, 8'h43};
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(12'h000, 32'(exp[i]));
        bus_read(12'h018, v);
        total++;
        if (v[7:0] !== 8'd3) begin bad++; $display("FAIL tx_level got=%0d want=3", v[7:0]); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (!tx_valid || tx_data !== exp[i]) begin
                bad++;
                $display("FAIL tx_order[%0d] got=%h/%b want=%h/1", i, tx_data, tx_valid, exp[i]);
            end
            tick();
        end
        tx_ready = 1'b0;
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drained got=%b want=0", tx_valid); end
        bus_read(12'h010, v);
        total++;
        if (v[0] !== 1'b1) begin bad++; $display("FAIL tx_empty got=%b want=1", v[0]); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] v;
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) bus_write(12'h000, 32'h10 + 32'(i));
        bus_read(12'h010, v);
        total++;
        if (v !== 32'h086) begin bad++; $display("FAIL ovf_status got=%h want=086", v); end
        bus_write(12'h010, 32'h080);
        bus_read(12'h010, v);
        total++;
        if (v !== 32'h006) begin bad++; $display("FAIL ovf_w1c got=%h want=006", v); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (tx_data !== 8'h10 + 8'(i)) begin
                bad++;
                $display("FAIL ovf_drain[%0d] got=%h want=%h", i, tx_data, 8'h10 + 8'(i));
            end
            tick();
        end
        tx_ready = 1'b0;
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("FAIL ovf_lost got=%b want=0", tx_valid); end
    endtask

    task automatic test_rx_fifo();
        logic [31:0] v;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i); parity_error = 1'b0;
            tick();
        end
        rx_valid = 1'b0;
        bus_read(12'h018, v);
        total++;
        if (v !== 32'h0800) begin bad++; $display("FAIL rx_level got=%h want=0800", v); end
        for (int i = 1; i <= 8; i++) begin
            bus_read(12'h004, v);
            total++;
            if (v !== 32'(i)) begin bad++; $display("FAIL rx_pop[%0d] got=%0d want=%0d", i, v, i); end
        end
        bus_read(12'h010, v);
        total++;
        if (v !== 32'h025) begin bad++; $display("FAIL rx_overrun got=%h want=025", v); end
        bus_read(12'h004, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL rx_empty_read got=%h want=0", v); end
        bus_read(12'h010, v);
        total++;
        if (v !== 32'h125) begin bad++; $display("FAIL rx_underflow got=%h want=125", v); end
    endtask

    task automatic test_irq_parity();
        logic [31:0] v;
        do_reset();
        bus_write(12'h014, 32'h040);
        rx_valid = 1'b1; parity_error = 1'b1; rx_data = 8'h55;
        tick();
        rx_valid = 1'b0; parity_error = 1'b0;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b want=0", irq); end
        tick();
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_parity got=%b want=1", irq); end
        waddr = 12'h010; wdata = 32'h040; pwrite = 1'b1;
        rx_valid = 1'b1; parity_error = 1'b1; rx_data = 8'h66;
        tick();
        pwrite = 1'b0; rx_valid = 1'b0; parity_error = 1'b0;
        bus_read(12'h010, v);
        total++;
        if (v !== 32'h041) begin bad++; $display("FAIL set_wins got=%h want=041", v); end
        bus_write(12'h010, 32'h040);
        bus_read(12'h010, v);
        total++;
        if (v !== 32'h001) begin bad++; $display("FAIL parity_w1c got=%h want=001", v); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_cleared got=%b want=0", irq); end
    endtask

    task automatic test_addr_err();
        logic [31:0] v;
        logic [11:0] bad_w [2] = '{12'h004, 12'h018};
        do_reset();
        bus_write(12'h008, 32'h15);
        bus_write(12'h00C, 32'h1234);
        waddr = 12'h020; wdata = 32'hFFFF_FFFF; pwrite = 1'b1;
        raddr = 12'h01C; pread = 1'b1;
        tick();
        pwrite = 1'b0; pread = 1'b0;
        total++;
        if ({wadderr, radderr} !== 2'b11) begin
            bad++; $display("FAIL adderr_pulse got=%b want=11", {wadderr, radderr});
        end
        tick();
        total++;
        if ({wadderr, radderr} !== 2'b00) begin
            bad++; $display("FAIL adderr_single got=%b want=00", {wadderr, radderr});
        end
        bus_read(12'h008, v);
        total++;
        if (v !== 32'h15) begin bad++; $display("FAIL adderr_cfg got=%h want=15", v); end
        total++;
        if ({parity_type, parity_en, stop_bit_num, data_bit_num} !== 5'h15) begin
            bad++;
            $display("FAIL cfg_outputs got=%h want=15",
                     {parity_type, parity_en, stop_bit_num, data_bit_num});
        end
        bus_read(12'h00C, v);
        total++;
        if (v !== 32'h1234 || baud_div !== 16'h1234) begin
            bad++; $display("FAIL adderr_baud got=%h/%h want=1234", v, baud_div);
        end
        bus_read(12'h010, v);
        total++;
        if (v !== 32'h005) begin bad++; $display("FAIL adderr_status got=%h want=005", v); end
        for (int i = 0; i < 2; i++) begin
            bus_write(bad_w[i], 32'h5A);
            total++;
            if (wadderr !== 1'b1) begin
                bad++; $display("FAIL ro_write[%h] got=%b want=1", bad_w[i], wadderr);
            end
        end
        bus_read(12'h000, v);
        total++;
        if (v !== 32'h0 || radderr !== 1'b0) begin
            bad++; $display("FAIL txdata_read got=%h/%b want=0/0", v, radderr);
        end
    endtask

    task automatic test_random();
        logic [7:0]  txq [$];
        logic [7:0]  rxq [$];
        logic [4:0]  m_cfg = '0;
        logic [15:0] m_baud = 16'd54;
        logic [8:0]  m_ier = '0;
        logic [4:0]  m_st = '0;  // sticky STATUS[8:4]
        logic [31:0] m_rdata = '0;
        logic [4:0]  set, clr;
        logic        exp_irq, exp_werr, exp_rerr, tpop, rpop, wr_tx;
        logic [7:0]  exp_txd;
        int          txn, rxn;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            pwrite = ($urandom_range(0, 2) != 0);
            waddr  = wa_tab[$urandom_range(0, 7)];
            wdata  = $urandom;
            pread  = ($urandom_range(0, 1) != 0);
            raddr  = ra_tab[$urandom_range(0, 7)];
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom);
            parity_error = ($urandom_range(0, 3) == 0);
            tx_ready = ($urandom_range(0, 2) == 0);
            tx_done  = ($urandom_range(0, 7) == 0);

            txn   = txq.size();
            rxn   = rxq.size();
            wr_tx = pwrite && waddr == 12'h000;
            tpop  = txn > 0 && tx_ready;
            rpop  = pread && raddr == 12'h004 && rxn > 0;
            exp_irq = (|(m_st & m_ier[8:4])) || (m_ier[0] && txn == 0) ||
                      (m_ier[2] && rxn != 0);
            exp_werr = pwrite && !(waddr inside {12'h000, 12'h008, 12'h00C, 12'h010, 12'h014});
            exp_rerr = pread && !(raddr inside {12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                                                12'h014, 12'h018});
            if (pread) begin
                case (raddr)
                    12'h004: m_rdata = (rxn > 0) ? 32'(rxq[0]) : 32'h0;
                    12'h008: m_rdata = 32'(m_cfg);
                    12'h00C: m_rdata = 32'(m_baud);
                    12'h010: m_rdata = 32'({m_st, rxn == 8, rxn == 0, txn == 8, txn == 0});
                    12'h014: m_rdata = 32'(m_ier);
                    12'h018: m_rdata = (32'(rxn) << 8) | 32'(txn);
                    default: m_rdata = 32'h0;
                endcase
            end
            set = {pread && raddr == 12'h004 && rxn == 0, wr_tx && txn == 8 && !tpop,
                   rx_valid && parity_error, rx_valid && rxn == 8 && !rpop, tx_done};
            clr = (pwrite && waddr == 12'h010) ? wdata[8:4] : 5'b0;
            m_st = (m_st & ~clr) | set;
            if (pwrite && waddr == 12'h008) m_cfg = wdata[4:0];
            if (pwrite && waddr == 12'h00C) m_baud = wdata[15:0];
            if (pwrite && waddr == 12'h014) m_ier = wdata[8:0];
            if (tpop) void'(txq.pop_front());
            if (wr_tx && (txn < 8 || tpop)) txq.push_back(wdata[7:0]);
            if (rpop) void'(rxq.pop_front());
            if (rx_valid && (rxn < 8 || rpop)) rxq.push_back(rx_data);

            tick();

            exp_txd = (txq.size() > 0) ? txq[0] : 8'h00;
            total++;
            if (tx_valid !== (txq.size() > 0) || tx_data !== exp_txd) begin
                bad++;
                $display("FAIL rnd_tx cyc=%0d got=%b/%h want=%b/%h", cyc, tx_valid, tx_data,
                         txq.size() > 0, exp_txd);
            end
            total++;
            if (rdata !== m_rdata) begin
                bad++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", cyc, rdata, m_rdata);
            end
            total++;
            if (irq !== exp_irq) begin
                bad++; $display("FAIL rnd_irq cyc=%0d got=%b want=%b", cyc, irq, exp_irq);
            end
            total++;
            if ({wadderr, radderr} !== {exp_werr, exp_rerr}) begin
                bad++;
                $display("FAIL rnd_adderr cyc=%0d got=%b%b want=%b%b", cyc, wadderr, radderr,
                         exp_werr, exp_rerr);
            end
            total++;
            if ({parity_type, parity_en, stop_bit_num, data_bit_num} !== m_cfg ||
                baud_div !== m_baud) begin
                bad++;
                $display("FAIL rnd_cfg cyc=%0d got=%h/%h want=%h/%h", cyc,
                         {parity_type, parity_en, stop_bit_num, data_bit_num}, baud_div,
                         m_cfg, m_baud);
            end
        end
        pwrite = 1'b0; pread = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; tx_done = 1'b0;
        parity_error = 1'b0;
    endtask

    initial begin
        reset = 1'b1; waddr = '0; raddr = '0; wdata = '0; pwrite = 1'b0; pread = 1'b0;
        tx_ready = 1'b0; tx_done = 1'b0; rx_valid = 1'b0; rx_data = '0; parity_error = 1'b0;
        test_reset();
        test_tx_fifo();
        test_tx_overflow();
        test_rx_fifo();
        test_irq_parity();
        test_addr_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
